// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: default widths and the
// branch opcode encodings used by the EX stage and the early-resolve path.
package branch_resolve_unit_pkg;

    localparam int BR_WORD       = 32;
    localparam int BR_OPCODE_LEN = 4;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_EQ   = 4'd1,
        BR_NE   = 4'd2,
        BR_LT   = 4'd3,
        BR_GE   = 4'd4,
        BR_LTU  = 4'd5,
        BR_GEU  = 4'd6,
        BR_B    = 4'd7,
        BR_BL   = 4'd8,
        BR_JIRL = 4'd9
    } br_op_e;

endpackage

// File: rtl/branch_resolve_unit_cond.sv
// Branch direction decision: purely combinational so the same comparator
// can later be dropped into an ID-stage early-resolve path unchanged.
module br_cond
    import branch_resolve_unit_pkg::*;
#(
    parameter int WORD       = BR_WORD,
    parameter int OPCODE_LEN = BR_OPCODE_LEN
) (
    input  logic [OPCODE_LEN-1:0] opcode_i,
    input  logic [WORD-1:0]       rj_i,
    input  logic [WORD-1:0]       rd_i,
    output logic                  taken_o
);

    // Decode the mode and evaluate its condition; unknown codes never branch.
    always_comb begin
        taken_o = 1'b0;
        case (opcode_i)
            OPCODE_LEN'(BR_EQ):   taken_o = (rj_i == rd_i);
            OPCODE_LEN'(BR_NE):   taken_o = (rj_i != rd_i);
            OPCODE_LEN'(BR_LT):   taken_o = ($signed(rj_i) <  $signed(rd_i));
            OPCODE_LEN'(BR_GE):   taken_o = ($signed(rj_i) >= $signed(rd_i));
            OPCODE_LEN'(BR_LTU):  taken_o = (rj_i <  rd_i);
            OPCODE_LEN'(BR_GEU):  taken_o = (rj_i >= rd_i);
            OPCODE_LEN'(BR_B),
            OPCODE_LEN'(BR_BL),
            OPCODE_LEN'(BR_JIRL): taken_o = 1'b1;
            default:              taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolve unit: resolves direction, target, link and
// redirect PC, checks the front-end prediction, and holds the result in one
// registered stage with valid/ready handshake, flush and perf counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int WORD       = BR_WORD,
    parameter int OPCODE_LEN = BR_OPCODE_LEN,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  cnt_clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPCODE_LEN-1:0] in_opcode,
    input  logic [WORD-1:0]       in_rj,
    input  logic [WORD-1:0]       in_rd,
    input  logic [WORD-1:0]       in_pc,
    input  logic [WORD-1:0]       in_offs,
    input  logic                  in_pred_taken,
    input  logic [WORD-1:0]       in_pred_target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_taken,
    output logic [WORD-1:0]       out_target,
    output logic [WORD-1:0]       out_link,
    output logic [WORD-1:0]       out_redirect_pc,
    output logic                  out_mispredict,
    output logic [CNT_W-1:0]      cnt_branch,
    output logic [CNT_W-1:0]      cnt_mispredict
);

    logic            taken_d;
    logic            is_jirl;
    logic            known_op;
    logic [WORD-1:0] base;
    logic [WORD-1:0] target_d;
    logic [WORD-1:0] link_d;
    logic [WORD-1:0] redirect_d;
    logic            mispredict_d;
    logic            accept;
    logic            retire;

    logic            valid_q;
    logic            taken_q;
    logic [WORD-1:0] target_q;
    logic [WORD-1:0] link_q;
    logic [WORD-1:0] redirect_q;
    logic            mispredict_q;
    logic [CNT_W-1:0] cnt_branch_q;
    logic [CNT_W-1:0] cnt_mispredict_q;

    br_cond #(
        .WORD       (WORD),
        .OPCODE_LEN (OPCODE_LEN)
    ) u_cond (
        .opcode_i (in_opcode),
        .rj_i     (in_rj),
        .rd_i     (in_rd),
        .taken_o  (taken_d)
    );

    // The stage frees up when empty or when the held result leaves this cycle;
    // flush blocks both capture and retirement.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign retire   = valid_q && out_ready && !flush;

    // Target, link, redirect and prediction check for the offered operands.
    always_comb begin
        is_jirl      = (in_opcode == OPCODE_LEN'(BR_JIRL));
        known_op     = (in_opcode >= OPCODE_LEN'(BR_EQ)) && (in_opcode <= OPCODE_LEN'(BR_JIRL));
        base         = is_jirl ? in_rj : in_pc;
        link_d       = in_pc + WORD'(4);
        target_d     = known_op ? (base + in_offs) : link_d;
        redirect_d   = taken_d ? target_d : link_d;
        mispredict_d = (taken_d != in_pred_taken) ||
                       (taken_d && in_pred_taken && (target_d != in_pred_target));
    end

    // Result register: loads on acceptance, empties on retirement, cleared by flush or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            taken_q      <= 1'b0;
            target_q     <= '0;
            link_q       <= '0;
            redirect_q   <= '0;
            mispredict_q <= 1'b0;
        end else if (flush) begin
            valid_q      <= 1'b0;
        end else if (accept) begin
            valid_q      <= 1'b1;
            taken_q      <= taken_d;
            target_q     <= target_d;
            link_q       <= link_d;
            redirect_q   <= redirect_d;
            mispredict_q <= mispredict_d;
        end else if (retire) begin
            valid_q      <= 1'b0;
        end
    end

    // Saturating perf counters, advanced only when a result actually leaves the stage.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_branch_q     <= '0;
            cnt_mispredict_q <= '0;
        end else if (retire) begin
            if (cnt_branch_q != {CNT_W{1'b1}}) begin
                cnt_branch_q <= cnt_branch_q + CNT_W'(1);
            end
            if (mispredict_q && (cnt_mispredict_q != {CNT_W{1'b1}})) begin
                cnt_mispredict_q <= cnt_mispredict_q + CNT_W'(1);
            end
        end
    end

    assign out_valid       = valid_q;
    assign out_taken       = taken_q;
    assign out_target      = target_q;
    assign out_link        = link_q;
    assign out_redirect_pc = redirect_q;
    assign out_mispredict  = mispredict_q;
    assign cnt_branch      = cnt_branch_q;
    assign cnt_mispredict  = cnt_mispredict_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit with a scoreboard of expected
// results and a reference model of the saturating counters (CNT_W = 4).
module tb_branch_resolve_unit;

    localparam int CNT_MAX = 15;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic [31:0] link;
        logic [31:0] redirect;
        logic        mispred;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_opcode = '0;
    logic [31:0] in_rj = '0;
    logic [31:0] in_rd = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_offs = '0;
    logic        in_pred_taken = 1'b0;
    logic [31:0] in_pred_target = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_taken;
    logic [31:0] out_target;
    logic [31:0] out_link;
    logic [31:0] out_redirect_pc;
    logic        out_mispredict;
    logic [3:0]  cnt_branch;
    logic [3:0]  cnt_mispredict;

    exp_t q[$];
    int   mCntBr = 0;
    int   mCntMp = 0;
    int   compCount = 0;
    int   errCount = 0;

    branch_resolve_unit #(
        .WORD       (32),
        .OPCODE_LEN (4),
        .CNT_W      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .cnt_clr         (cnt_clr),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_opcode       (in_opcode),
        .in_rj           (in_rj),
        .in_rd           (in_rd),
        .in_pc           (in_pc),
        .in_offs         (in_offs),
        .in_pred_taken   (in_pred_taken),
        .in_pred_target  (in_pred_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_taken       (out_taken),
        .out_target      (out_target),
        .out_link        (out_link),
        .out_redirect_pc (out_redirect_pc),
        .out_mispredict  (out_mispredict),
        .cnt_branch      (cnt_branch),
        .cnt_mispredict  (cnt_mispredict)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t computeExp(input logic [3:0] op, input logic [31:0] rj, input logic [31:0] rd,
                                        input logic [31:0] pc, input logic [31:0] offs,
                                        input logic pt, input logic [31:0] ptgt);
        exp_t e;
        case (op)
            4'd1:    e.taken = (rj == rd);
            4'd2:    e.taken = (rj != rd);
            4'd3:    e.taken = ($signed(rj) < $signed(rd));
            4'd4:    e.taken = !($signed(rj) < $signed(rd));
            4'd5:    e.taken = (rj < rd);
            4'd6:    e.taken = !(rj < rd);
            4'd7, 4'd8, 4'd9: e.taken = 1'b1;
            default: e.taken = 1'b0;
        endcase
        e.link = pc + 32'd4;
        if (op == 4'd9)                     e.target = rj + offs;
        else if (op >= 4'd1 && op <= 4'd8)  e.target = pc + offs;
        else                                e.target = pc + 32'd4;
        e.redirect = e.taken ? e.target : e.link;
        if (e.taken != pt)  e.mispred = 1'b1;
        else if (e.taken)   e.mispred = (e.target != ptgt);
        else                e.mispred = 1'b0;
        return e;
    endfunction

    // Scoreboard monitor: checks outputs mid-cycle, then advances the model for the coming edge.
    always @(negedge clk) begin
        exp_t e;
        logic ready;
        logic retire;
        if (!rst) begin
            checkOutput("outValid", 32'(out_valid), 32'(q.size() != 0));
            checkOutput("inReady", 32'(in_ready), 32'((q.size() == 0) || out_ready));
            checkOutput("cntBranch", 32'(cnt_branch), 32'(mCntBr));
            checkOutput("cntMispredict", 32'(cnt_mispredict), 32'(mCntMp));
            if (q.size() != 0) begin
                e = q[0];
                checkOutput("taken", 32'(out_taken), 32'(e.taken));
                checkOutput("target", out_target, e.target);
                checkOutput("link", out_link, e.link);
                checkOutput("redirect", out_redirect_pc, e.redirect);
                checkOutput("mispredict", 32'(out_mispredict), 32'(e.mispred));
            end
        end
        if (rst) begin
            q.delete();
            mCntBr = 0;
            mCntMp = 0;
        end else if (flush) begin
            q.delete();
            if (cnt_clr) begin
                mCntBr = 0;
                mCntMp = 0;
            end
        end else begin
            ready  = (q.size() == 0) || out_ready;
            retire = (q.size() != 0) && out_ready;
            if (cnt_clr) begin
                mCntBr = 0;
                mCntMp = 0;
            end else if (retire) begin
                if (mCntBr < CNT_MAX) mCntBr++;
                if (q[0].mispred && mCntMp < CNT_MAX) mCntMp++;
            end
            if (retire) void'(q.pop_front());
            if (in_valid && ready)
                q.push_back(computeExp(in_opcode, in_rj, in_rd, in_pc, in_offs, in_pred_taken, in_pred_target));
        end
    end

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] rj, input logic [31:0] rd,
                                 input logic [31:0] pc, input logic [31:0] offs,
                                 input logic pt, input logic [31:0] ptgt);
        logic accepted;
        accepted       = 1'b0;
        in_valid       = 1'b1;
        in_opcode      = op;
        in_rj          = rj;
        in_rd          = rd;
        in_pc          = pc;
        in_offs        = offs;
        in_pred_taken  = pt;
        in_pred_target = ptgt;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            accepted = in_ready && !flush;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        if (!accepted) checkOutput("acceptTimeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) checkOutput("drainTimeout", 32'(q.size()), 32'd0);
        #2;
    endtask

    task automatic pulseClear();
        cnt_clr = 1'b1;
        @(posedge clk);
        #2;
        cnt_clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // Reset state of the data outputs
        @(negedge clk);
        checkOutput("rstTarget", out_target, 32'd0);
        checkOutput("rstLink", out_link, 32'd0);
        checkOutput("rstRedirect", out_redirect_pc, 32'd0);
        checkOutput("rstTaken", 32'(out_taken), 32'd0);
        @(posedge clk);
        #2;

        // Signed vs unsigned on the same operands
        applyStimulus(4'd4, 32'hFFFF_FFFF, 32'd1, 32'h1C00_0000, 32'h10, 1'b0, 32'h0);
        applyStimulus(4'd6, 32'hFFFF_FFFF, 32'd1, 32'h1C00_0000, 32'h10, 1'b0, 32'h0);
        applyStimulus(4'd5, 32'hFFFF_FFFF, 32'd1, 32'h1C00_0000, 32'h10, 1'b0, 32'h0);
        applyStimulus(4'd3, 32'hFFFF_FFFF, 32'd1, 32'h1C00_0000, 32'h10, 1'b1, 32'h1C00_0010);
        // JIRL with correct and wrong predicted target, then link wrap
        applyStimulus(4'd9, 32'h8000_0000, 32'd0, 32'h1C00_0100, 32'hFFFF_FFFC, 1'b1, 32'h7FFF_FFFC);
        applyStimulus(4'd9, 32'h8000_0000, 32'd0, 32'h1C00_0100, 32'hFFFF_FFFC, 1'b1, 32'h8000_0000);
        applyStimulus(4'd9, 32'h8000_0000, 32'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 32'h7FFF_FFFC);
        // Remaining modes, unknown codes, NT/NT with junk predicted target
        applyStimulus(4'd1, 32'h1234, 32'h1234, 32'h400, 32'h20, 1'b1, 32'h420);
        applyStimulus(4'd2, 32'h1234, 32'h1234, 32'h400, 32'h20, 1'b0, 32'hDEAD_BEEF);
        applyStimulus(4'd7, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h20, 1'b1, 32'h10);
        applyStimulus(4'd8, 32'h0, 32'h0, 32'h500, 32'hFFFF_FF00, 1'b0, 32'h0);
        applyStimulus(4'd0, 32'h5, 32'h5, 32'h600, 32'h40, 1'b0, 32'h640);
        applyStimulus(4'd12, 32'h5, 32'h5, 32'h600, 32'h40, 1'b1, 32'h604);
        applyStimulus(4'd15, 32'h5, 32'h6, 32'h600, 32'h40, 1'b0, 32'h0);
        drain();

        // Backpressure: held result with a queued input for three cycles
        out_ready = 1'b0;
        applyStimulus(4'd7, 32'h0, 32'h0, 32'h1000, 32'h80, 1'b0, 32'h0);
        fork
            applyStimulus(4'd1, 32'h7, 32'h7, 32'h2000, 32'h8, 1'b1, 32'h2008);
            begin
                repeat (3) @(posedge clk);
                #2;
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush with a held result and an offered input
        out_ready = 1'b0;
        applyStimulus(4'd7, 32'h0, 32'h0, 32'h3000, 32'h80, 1'b0, 32'h0);
        in_valid  = 1'b1;
        in_opcode = 4'd8;
        flush     = 1'b1;
        @(posedge clk);
        #2;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("flushValid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #2;

        // Reset while a result is held
        out_ready = 1'b0;
        applyStimulus(4'd9, 32'h4000, 32'h0, 32'h1234_5678, 32'h4, 1'b0, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("midRstValid", 32'(out_valid), 32'd0);
        checkOutput("midRstLink", out_link, 32'd0);
        checkOutput("midRstCnt", 32'(cnt_branch), 32'd0);
        @(posedge clk);
        #2;

        // Random mix at full throughput
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = (i % 4 == 0) ? a : $urandom;
            applyStimulus(4'($urandom_range(0, 15)), a, b, $urandom, $urandom,
                          1'($urandom_range(0, 1)), $urandom);
        end
        drain();

        // Saturation: 20 mispredicting branches on cleared counters
        pulseClear();
        for (int i = 0; i < 20; i++)
            applyStimulus(4'd7, 32'h0, 32'h0, 32'(i * 16), 32'h100, 1'b0, 32'h0);
        drain();
        @(negedge clk);
        checkOutput("satBranch", 32'(cnt_branch), 32'd15);
        checkOutput("satMispredict", 32'(cnt_mispredict), 32'd15);
        @(posedge clk);
        #2;
        pulseClear();
        @(negedge clk);
        checkOutput("clrBranch", 32'(cnt_branch), 32'd0);
        checkOutput("clrMispredict", 32'(cnt_mispredict), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
